sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares the single-port 128K x 8 synchronous SRAM between the AVR core data port and one secondary requester (DMA/video/UART loader). The core has default priority and sees the memory as if it were private; the secondary port gets idle cycles and, under contention, a guaranteed slot every STARVE+1 cycles. The block sits between the core's `address`/`data_o`/`wren`/`data_i` lines and the SRAM controller, and drives a stall to the core when it loses a cycle.

## Interface
- AW, 17, SRAM address width (byte addresses)
- STARVE, 4, max consecutive contended cycles the DMA port waits before a forced grant (0 = DMA always wins)

- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  core accesses SRAM this cycle (read or write)
- cpu_address  in  16  core byte address, zero-extended to AW
- cpu_data_o  in  8  core write data
- cpu_wren  in  1  core write strobe (qualified by cpu_req)
- cpu_data_i  out  8  read data returned to core
- cpu_stall  out  1  core must hold its request and repeat it next cycle
- dma_req  in  1  secondary access request; fields held stable until dma_ack
- dma_we  in  1  1 = write, 0 = read
- dma_address  in  AW  secondary byte address
- dma_wdata  in  8  secondary write data
- dma_ack  out  1  request accepted this cycle (combinational)
- dma_rvalid  out  1  dma_rdata valid (one cycle after a read ack)
- dma_rdata  out  8  read data for secondary port
- mem_address  out  AW  to SRAM
- mem_data_o  out  8  to SRAM
- mem_wren  out  1  to SRAM
- mem_data_i  in  8  from SRAM, valid the cycle after the address (registered read)

## Operation
- Per-cycle grant, combinational: gnt_dma = dma_req & (~cpu_req | starve_cnt == STARVE); otherwise core owns the port.
- Core owner: mem_address = {0, cpu_address}, mem_data_o = cpu_data_o, mem_wren = cpu_req & cpu_wren; dma_ack = 0, cpu_stall = 0.
- DMA owner: mem_* from dma_*, mem_wren = dma_we; dma_ack = 1; cpu_stall = cpu_req.
- starve_cnt (sequential, saturating at STARVE): +1 when dma_req & cpu_req & ~gnt_dma; cleared to 0 on gnt_dma or ~dma_req.
- Register last_owner (CPU/DMA) and last_rd (access was a read) each cycle.
- dma_rvalid <= gnt_dma & ~dma_we; dma_rdata = mem_data_i when dma_rvalid, else holds last value.
- cpu_data_i = mem_data_i when last_owner = CPU; otherwise cpu_hold, a register loaded with mem_data_i on every cycle whose last_owner = CPU. Core never observes DMA read data.
- Forced grant costs exactly one core cycle; counter clears, so next forced grant is ≥ STARVE+1 cycles later.

## Timing
- Reset (synchronous): last_owner = CPU, starve_cnt = 0, dma_rvalid = 0, dma_rdata = 0, cpu_hold = 0. While reset high: mem_wren = 0, dma_ack = 0, cpu_stall = 0, regardless of requests.
- Reset asserted mid-DMA-read: pending dma_rvalid is dropped (0 next cycle); requester must reissue.
- Read latency: 1 cycle both ports (address at edge N, data at edge N+1).
- Write: committed at the edge where mem_wren is high; no read-after-write forwarding needed (SRAM is write-first-by-cycle).
- Back-to-back DMA with idle core: one access per cycle, dma_ack high each cycle.
- Simultaneous cpu_req and dma_req, starve_cnt < STARVE: core wins, no stall.
- STARVE = 0: DMA wins every contended cycle; core can starve (documented, loader-only use).
- dma_req dropped before ack: no access, counter cleared.

## Test plan
- Idle DMA: core writes 0x5A to 0x0100, reads it next cycle -> cpu_data_i = 0x5A one cycle after read, cpu_stall never high.
- Idle core: DMA writes 0xC3 to 0x1FFFF, then reads it -> dma_ack each cycle, dma_rvalid with dma_rdata = 0xC3 one cycle after read ack.
- Contention, STARVE = 4: cpu_req and dma_req held high continuously -> dma_ack on cycles 5, 10, 15…; cpu_stall high exactly on those cycles.
- Data isolation: core reads 0x0010 (=0x11), next cycle forced DMA read of 0x0020 (=0x22) -> cpu_data_i stays 0x11 during DMA cycle, dma_rdata = 0x22.
- Reset mid-operation: assert reset in the cycle after a DMA read ack -> dma_rvalid = 0, mem_wren = 0, starve_cnt = 0 afterwards.
- STARVE = 0 with both requesting -> dma_ack every cycle, cpu_stall every cycle, no core writes reach SRAM.

Source files
------------

// File: rtl/sram_arbiter.sv
// Shares one single-port synchronous SRAM between the AVR core data port and a
// secondary requester; the core has default priority, the secondary port gets idle cycles plus a forced slot.
module sram_arbiter #(
  parameter int AW     = 17,
  parameter int STARVE = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic [15:0]   cpu_address,
  input  logic [7:0]    cpu_data_o,
  input  logic          cpu_wren,
  output logic [7:0]    cpu_data_i,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_address,
  input  logic [7:0]    dma_wdata,
  output logic          dma_ack,
  output logic          dma_rvalid,
  output logic [7:0]    dma_rdata,
  output logic [AW-1:0] mem_address,
  output logic [7:0]    mem_data_o,
  output logic          mem_wren,
  input  logic [7:0]    mem_data_i
);

  localparam int CW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE);

  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;

  logic [CW-1:0] starve_cnt_p1;
  owner_t        last_owner_p1;
  logic          last_rd_p1;
  logic [7:0]    cpu_hold_p1;
  logic [7:0]    dma_hold_p1;
  logic          gnt_dma;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == STARVE_MAX) ? v : v + 1'b1;
  endfunction

  assign gnt_dma = dma_req & (~cpu_req | (starve_cnt_p1 == STARVE_MAX));

  // Stage 0: combinational grant and SRAM port mux
  always_comb begin
    mem_address = AW'(cpu_address);
    mem_data_o  = cpu_data_o;
    mem_wren    = cpu_req & cpu_wren;
    dma_ack     = 1'b0;
    cpu_stall   = 1'b0;
    if (gnt_dma) begin
      mem_address = dma_address;
      mem_data_o  = dma_wdata;
      mem_wren    = dma_we;
      dma_ack     = 1'b1;
      cpu_stall   = cpu_req;
    end
    if (reset) begin
      mem_wren  = 1'b0;
      dma_ack   = 1'b0;
      cpu_stall = 1'b0;
    end
  end

  // Stage 1: ownership history and read-data steering for the returning cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_p1 <= '0;
      last_owner_p1 <= OWN_CPU;
      last_rd_p1    <= 1'b0;
      cpu_hold_p1   <= 8'h00;
      dma_hold_p1   <= 8'h00;
    end else begin
      starve_cnt_p1 <= (gnt_dma | ~dma_req) ? '0 : sat_inc(starve_cnt_p1);
      last_owner_p1 <= gnt_dma ? OWN_DMA : OWN_CPU;
      last_rd_p1    <= gnt_dma ? ~dma_we : (cpu_req & ~cpu_wren);
      if (last_owner_p1 == OWN_CPU)
        cpu_hold_p1 <= mem_data_i;
      if (dma_rvalid)
        dma_hold_p1 <= mem_data_i;
    end
  end

  assign dma_rvalid = (last_owner_p1 == OWN_DMA) & last_rd_p1;
  assign dma_rdata  = dma_rvalid ? mem_data_i : dma_hold_p1;
  // The core only ever sees data fetched on its own cycles.
  assign cpu_data_i = (last_owner_p1 == OWN_CPU) ? mem_data_i : cpu_hold_p1;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM, scoreboard queues for read data,
// one task per scenario. A second instance runs with STARVE = 0.
module tb_sram_arbiter;

  logic        clock;
  logic        reset;
  logic        cpu_req, cpu_wren, cpu_stall;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_data_o, cpu_data_i;
  logic        dma_req, dma_we, dma_ack, dma_rvalid;
  logic [16:0] dma_address, mem_address;
  logic [7:0]  dma_wdata, dma_rdata, mem_data_o, mem_data_i;
  logic        mem_wren;

  logic        z_cpu_req, z_cpu_wren, z_cpu_stall;
  logic [15:0] z_cpu_address;
  logic [7:0]  z_cpu_data_o, z_cpu_data_i;
  logic        z_dma_req, z_dma_we, z_dma_ack, z_dma_rvalid;
  logic [16:0] z_dma_address, z_mem_address;
  logic [7:0]  z_dma_wdata, z_dma_rdata, z_mem_data_o, z_mem_data_i;
  logic        z_mem_wren;

  logic [7:0]  sram [0:131071];
  logic [7:0]  cpu_q[$];
  logic [7:0]  dma_q[$];
  logic [7:0]  exp_v;
  int          checks = 0;
  int          passed = 0;

  sram_arbiter #(.AW(17), .STARVE(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_data_o(cpu_data_o),
    .cpu_wren(cpu_wren), .cpu_data_i(cpu_data_i), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_address(dma_address),
    .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rvalid(dma_rvalid),
    .dma_rdata(dma_rdata), .mem_address(mem_address), .mem_data_o(mem_data_o),
    .mem_wren(mem_wren), .mem_data_i(mem_data_i)
  );

  sram_arbiter #(.AW(17), .STARVE(0)) dut_z (
    .clock(clock), .reset(reset),
    .cpu_req(z_cpu_req), .cpu_address(z_cpu_address), .cpu_data_o(z_cpu_data_o),
    .cpu_wren(z_cpu_wren), .cpu_data_i(z_cpu_data_i), .cpu_stall(z_cpu_stall),
    .dma_req(z_dma_req), .dma_we(z_dma_we), .dma_address(z_dma_address),
    .dma_wdata(z_dma_wdata), .dma_ack(z_dma_ack), .dma_rvalid(z_dma_rvalid),
    .dma_rdata(z_dma_rdata), .mem_address(z_mem_address), .mem_data_o(z_mem_data_o),
    .mem_wren(z_mem_wren), .mem_data_i(z_mem_data_i)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_wren) sram[mem_address] <= mem_data_o;
    mem_data_i <= sram[mem_address];
  end

  assign z_mem_data_i = 8'hA5;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_all();
    cpu_req = 0; cpu_wren = 0; dma_req = 0; dma_we = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    cpu_req = 1; cpu_wren = 1; cpu_address = 16'h0100; cpu_data_o = 8'hEE;
    dma_req = 1; dma_we = 1; dma_address = 17'h00200; dma_wdata = 8'hDD;
    #1;
    checks++;
    if ({mem_wren, dma_ack, cpu_stall} !== 3'b000)
      $display("FAIL reset_outputs: wren/ack/stall=%b required 000", {mem_wren, dma_ack, cpu_stall});
    else passed++;
    step(); step();
    checks++;
    if (dma_rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b required 0", dma_rvalid);
    else passed++;
    checks++;
    if (dma_rdata !== 8'h00) $display("FAIL reset_rdata: got %h required 00", dma_rdata);
    else passed++;
    idle_all();
    reset = 0;
    step();
  endtask

  task automatic test_cpu_idle_dma();
    cpu_req = 1; cpu_wren = 1; cpu_address = 16'h0100; cpu_data_o = 8'h5A;
    #1;
    checks++;
    if ({cpu_stall, mem_wren, mem_address} !== {1'b0, 1'b1, 17'h00100})
      $display("FAIL cpu_write: stall/wren/addr=%b/%b/%h required 0/1/00100", cpu_stall, mem_wren, mem_address);
    else passed++;
    step();
    cpu_wren = 0;
    cpu_q.push_back(8'h5A);
    #1;
    checks++;
    if ({cpu_stall, mem_wren} !== 2'b00)
      $display("FAIL cpu_read_issue: stall/wren=%b required 00", {cpu_stall, mem_wren});
    else passed++;
    step();
    cpu_req = 0;
    checks++;
    if (cpu_q.size() == 0) $display("FAIL cpu_q_empty: got 0 entries required 1");
    else begin
      exp_v = cpu_q.pop_front();
      if (cpu_data_i !== exp_v) $display("FAIL cpu_read_data: got %h required %h", cpu_data_i, exp_v);
      else passed++;
    end
    step();
  endtask

  task automatic test_dma_idle_core();
    dma_req = 1; dma_we = 1; dma_address = 17'h1FFFF; dma_wdata = 8'hC3;
    #1;
    checks++;
    if ({dma_ack, mem_wren, mem_address, mem_data_o} !== {1'b1, 1'b1, 17'h1FFFF, 8'hC3})
      $display("FAIL dma_write: ack/wren/addr/data=%b/%b/%h/%h required 1/1/1ffff/c3", dma_ack, mem_wren, mem_address, mem_data_o);
    else passed++;
    step();
    dma_we = 0;
    dma_q.push_back(8'hC3);
    #1;
    checks++;
    if ({dma_ack, mem_wren} !== 2'b10) $display("FAIL dma_read_ack: ack/wren=%b required 10", {dma_ack, mem_wren});
    else passed++;
    step();
    dma_req = 0;
    checks++;
    if (dma_rvalid !== 1'b1) $display("FAIL dma_rvalid: got %b required 1", dma_rvalid);
    else passed++;
    checks++;
    if (dma_q.size() == 0) $display("FAIL dma_q_empty: got 0 entries required 1");
    else begin
      exp_v = dma_q.pop_front();
      if (dma_rdata !== exp_v) $display("FAIL dma_read_data: got %h required %h", dma_rdata, exp_v);
      else passed++;
    end
    step();
    checks++;
    if ({dma_rvalid, dma_rdata} !== {1'b0, 8'hC3})
      $display("FAIL dma_rdata_hold: rvalid/rdata=%b/%h required 0/c3", dma_rvalid, dma_rdata);
    else passed++;
  endtask

  task automatic test_contention();
    idle_all();
    step();
    cpu_req = 1; cpu_wren = 0; cpu_address = 16'h0000;
    dma_req = 1; dma_we = 0; dma_address = 17'h00040;
    for (int k = 1; k <= 15; k++) begin
      #1;
      checks++;
      if ({dma_ack, cpu_stall} !== {2{(k % 5) == 0}})
        $display("FAIL contention_c%0d: ack/stall=%b required %b", k, {dma_ack, cpu_stall}, {2{(k % 5) == 0}});
      else passed++;
      step();
    end
    idle_all();
    step();
  endtask

  task automatic test_isolation();
    cpu_req = 1; cpu_wren = 1; cpu_address = 16'h0010; cpu_data_o = 8'h11;
    step();
    cpu_address = 16'h0020; cpu_data_o = 8'h22;
    step();
    idle_all();
    step();
    cpu_req = 1; cpu_wren = 0; cpu_address = 16'h0010;
    dma_req = 1; dma_we = 0; dma_address = 17'h00020;
    for (int k = 1; k <= 4; k++) step();
    cpu_q.push_back(8'h11);
    #1;
    checks++;
    if ({dma_ack, cpu_stall} !== 2'b11) $display("FAIL iso_forced: ack/stall=%b required 11", {dma_ack, cpu_stall});
    else passed++;
    checks++;
    if (cpu_q.size() == 0) $display("FAIL cpu_q_empty: got 0 entries required 1");
    else begin
      exp_v = cpu_q.pop_front();
      if (cpu_data_i !== exp_v) $display("FAIL iso_cpu_before: got %h required %h", cpu_data_i, exp_v);
      else passed++;
    end
    dma_q.push_back(8'h22);
    step();
    dma_req = 0;
    checks++;
    if (cpu_data_i !== 8'h11) $display("FAIL iso_cpu_during: got %h required 11", cpu_data_i);
    else passed++;
    checks++;
    if (dma_q.size() == 0) $display("FAIL dma_q_empty: got 0 entries required 1");
    else begin
      exp_v = dma_q.pop_front();
      if ({dma_rvalid, dma_rdata} !== {1'b1, exp_v})
        $display("FAIL iso_dma_data: rvalid/rdata=%b/%h required 1/%h", dma_rvalid, dma_rdata, exp_v);
      else passed++;
    end
    step();
    idle_all();
    checks++;
    if (cpu_data_i !== 8'h11) $display("FAIL iso_cpu_repeat: got %h required 11", cpu_data_i);
    else passed++;
    step();
  endtask

  task automatic test_reset_mid();
    dma_req = 1; dma_we = 0; dma_address = 17'h1FFFF;
    dma_q.push_back(8'hC3);
    #1;
    checks++;
    if (dma_ack !== 1'b1) $display("FAIL rmid_ack: got %b required 1", dma_ack);
    else passed++;
    step();
    reset = 1;
    cpu_req = 1; cpu_wren = 1; cpu_address = 16'h0030; cpu_data_o = 8'h77;
    dma_req = 1; dma_we = 1; dma_wdata = 8'h99;
    #1;
    checks++;
    if ({mem_wren, dma_ack, cpu_stall} !== 3'b000)
      $display("FAIL rmid_in_reset: wren/ack/stall=%b required 000", {mem_wren, dma_ack, cpu_stall});
    else passed++;
    checks++;
    if (dma_q.size() == 0) $display("FAIL dma_q_empty: got 0 entries required 1");
    else begin
      exp_v = dma_q.pop_front();
      if ({dma_rvalid, dma_rdata} !== {1'b1, exp_v})
        $display("FAIL rmid_data: rvalid/rdata=%b/%h required 1/%h", dma_rvalid, dma_rdata, exp_v);
      else passed++;
    end
    step();
    reset = 0;
    cpu_wren = 0; dma_we = 0;
    checks++;
    if (dma_rvalid !== 1'b0) $display("FAIL rmid_rvalid_drop: got %b required 0", dma_rvalid);
    else passed++;
    for (int k = 1; k <= 5; k++) begin
      #1;
      checks++;
      if (dma_ack !== (k == 5)) $display("FAIL rmid_cnt_c%0d: ack=%b required %b", k, dma_ack, (k == 5));
      else passed++;
      step();
    end
    idle_all();
    step();
  endtask

  task automatic test_starve0();
    z_cpu_req = 1; z_cpu_wren = 1; z_cpu_address = 16'h0050; z_cpu_data_o = 8'h5F;
    z_dma_req = 1; z_dma_we = 0; z_dma_address = 17'h10000;
    for (int k = 1; k <= 6; k++) begin
      #1;
      checks++;
      if ({z_dma_ack, z_cpu_stall, z_mem_wren} !== 3'b110)
        $display("FAIL starve0_c%0d: ack/stall/wren=%b required 110", k, {z_dma_ack, z_cpu_stall, z_mem_wren});
      else passed++;
      step();
    end
    z_cpu_req = 0; z_dma_req = 0;
  endtask

  initial begin
    reset = 1;
    idle_all();
    cpu_address = 16'h0; cpu_data_o = 8'h0;
    dma_address = 17'h0; dma_wdata = 8'h0;
    z_cpu_req = 0; z_cpu_wren = 0; z_cpu_address = 16'h0; z_cpu_data_o = 8'h0;
    z_dma_req = 0; z_dma_we = 0; z_dma_address = 17'h0; z_dma_wdata = 8'h0;
    step();
    test_reset();
    test_cpu_idle_dma();
    test_dma_idle_core();
    test_contention();
    test_isolation();
    test_reset_mid();
    test_starve0();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
